// File: rtl/cmos_pix_pack.sv
// rtl/cmos_pix_pack.sv - packs RGB565 pixels into DATA_W-bit FIFO words with vs frame tracking
// Optional feature macro: PACK_LINE_FLUSH_EN (zero-pad and write the partial word at each de falling edge)
module cmos_pix_pack #(
    parameter int DATA_W = 128,
    parameter bit VS_POL = 1'b1
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [15:0]       pdata_i,
    input  logic              de_i,
    input  logic              vs_i,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic [23:0]       frame_words,
    output logic              ovf_err
);
    localparam int N  = DATA_W / 16;
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);
    localparam logic [23:0]   CNT_MAX   = 24'hFF_FFFF;

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

    state_t            state_q, state_d;
    logic              vs_1d_q;
    logic [LW-1:0]     lane_q, lane_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [23:0]       cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic [23:0]       frame_words_q, frame_words_d;
    logic              ovf_err_q, ovf_err_d;

    logic              vs_edge, pix_in, word_done, flush_req, issue, ovf;
    logic [LW-1:0]     wr_lane;
    logic [DATA_W-1:0] base_word, packed_word;

    assign vs_edge   = (vs_i == VS_POL) && (vs_1d_q != VS_POL);
    // A pixel arriving with the frame-start edge already belongs to the new frame.
    assign pix_in    = de_i && (vs_edge || (state_q == ACTIVE));
    assign wr_lane   = vs_edge ? '0 : lane_q;
    assign base_word = vs_edge ? '0 : word_q;
    assign word_done = pix_in && (wr_lane == LAST_LANE);

`ifdef PACK_LINE_FLUSH_EN
    logic de_1d_q;
    always_ff @(posedge pixel_clk) begin
        if (rst) de_1d_q <= 1'b0;
        else     de_1d_q <= de_i;
    end
    // de falling implies no pixel this cycle, so flush and word completion are exclusive.
    assign flush_req = !vs_edge && (state_q == ACTIVE) && de_1d_q && !de_i && (lane_q != '0);
`else
    assign flush_req = 1'b0;
`endif

    assign issue = word_done || flush_req;
    assign ovf   = issue && wr_full;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            vs_1d_q       <= 1'b0;
            lane_q        <= '0;
            word_q        <= '0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_words_q <= '0;
            ovf_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_1d_q       <= vs_i;
            lane_q        <= lane_d;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_words_q <= frame_words_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vs_edge)
            state_d = ACTIVE;
        else if ((state_q == ACTIVE) && ovf)
            state_d = DROP;
    end

    always_comb begin
        packed_word = base_word;
        if (pix_in)
            packed_word[16*wr_lane +: 16] = pdata_i;

        word_d = packed_word;
        lane_d = pix_in ? wr_lane + LW'(1) : wr_lane;
        // Clearing after every issued word keeps unfilled lanes of a flushed word at zero.
        if (issue) begin
            word_d = '0;
            lane_d = '0;
        end

        wr_en_d   = issue && !wr_full;
        wr_data_d = wr_en_d ? packed_word : wr_data_q;

        cnt_d = vs_edge ? 24'd0 : cnt_q;
        if (wr_en_d && (cnt_d != CNT_MAX))
            cnt_d = cnt_d + 24'd1;

        frame_start_d = vs_edge;
        frame_done_d  = vs_edge && (state_q == ACTIVE);
        frame_words_d = frame_done_d ? cnt_q : frame_words_q;
        ovf_err_d     = ovf_err_q || ovf;
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_words = frame_words_q;
    assign ovf_err     = ovf_err_q;
endmodule

// File: tb/tb_cmos_pix_pack.sv
// tb/tb_cmos_pix_pack.sv - directed scoreboard bench for cmos_pix_pack
module tb_cmos_pix_pack;
    localparam int DW = 128;
    localparam int N  = DW / 16;
`ifdef PACK_LINE_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic          pixel_clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   pdata_i = '0;
    logic          de_i = 1'b0;
    logic          vs_i = 1'b0;
    logic          wr_full = 1'b0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          frame_start;
    logic          frame_done;
    logic [23:0]   frame_words;
    logic          ovf_err;

    cmos_pix_pack #(.DATA_W(DW), .VS_POL(1'b1)) dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .pdata_i     (pdata_i),
        .de_i        (de_i),
        .vs_i        (vs_i),
        .wr_full     (wr_full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_words (frame_words),
        .ovf_err     (ovf_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state (0 idle, 1 active, 2 drop)
    int            m_state = 0;
    int            m_lane = 0;
    logic [DW-1:0] m_word = '0;
    int            m_cnt = 0;
    logic          m_vs1d = 1'b0;
    logic          m_de1d = 1'b0;
    logic          e_fs = 1'b0;
    logic          e_fd = 1'b0;
    logic          e_ovf = 1'b0;
    logic [23:0]   e_fw = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic issue_word(input logic full);
        if (full) begin
            e_ovf   = 1'b1;
            m_state = 2;
        end else begin
            sb.push_back('{m_word, cyc + 1});
            m_cnt++;
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("frame_start", frame_start, e_fs);
        chk("frame_done", frame_done, e_fd);
        chk("frame_words", frame_words, e_fw);
        chk("ovf_err", ovf_err, e_ovf);
        if (wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr_en", wr_en, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_data", wr_data, e.data);
                chk("wr_latency", cyc, e.cyc);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            chk("missing_wr_en", wr_en, 1);
            e = sb.pop_front();
        end
    endtask

    task automatic drive(input logic de, input logic [15:0] pd, input logic vs, input logic full);
        logic vs_edge;
        vs_edge = vs && !m_vs1d;
        e_fs = vs_edge;
        e_fd = vs_edge && (m_state == 1);
        if (e_fd) e_fw = 24'(m_cnt);
        if (vs_edge) begin
            m_state = 1;
            m_lane  = 0;
            m_word  = '0;
            m_cnt   = 0;
        end else if (FLUSH && m_state == 1 && m_de1d && !de && m_lane != 0) begin
            issue_word(full);
            m_lane = 0;
            m_word = '0;
        end
        if (m_state == 1 && de) begin
            m_word[16*m_lane +: 16] = pd;
            m_lane++;
            if (m_lane == N) begin
                issue_word(full);
                m_lane = 0;
                m_word = '0;
            end
        end
        m_vs1d = vs;
        m_de1d = de;

        de_i = de; pdata_i = pd; vs_i = vs; wr_full = full;
        @(posedge pixel_clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    // n contiguous pixels first..first+n-1 with vs held high; wr_full raised on pixel index full_idx
    task automatic px_run(input int n, input int first, input int full_idx);
        for (int i = 0; i < n; i++)
            drive(1'b1, 16'(first + i), 1'b1, (i == full_idx));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic new_frame();
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            de_i = 1'($urandom); vs_i = 1'($urandom);
            pdata_i = 16'($urandom); wr_full = 1'($urandom);
            @(posedge pixel_clk);
            cyc++;
            #1;
        end
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_words", frame_words, 0);
        chk("rst_ovf_err", ovf_err, 0);
        rst = 1'b0;

        // IDLE: de toggling without a vs edge must not write
        for (int i = 0; i < 12; i++)
            drive(i[0], 16'($urandom), 1'b0, 1'b0);

        // Frame start then 16 contiguous pixels
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        px_run(16, 16'h0001, -1);
        idle(2);
        chk("t2_drained", sb.size(), 0);

        // Line of 10, gap, line of 6
        new_frame();
        px_run(10, 16'h0001, -1);
        idle(2);
        px_run(6, 16'h000B, -1);
        idle(3);
        chk("t3_drained", sb.size(), 0);

        // Overflow on the second word completion, trailing pixels dropped
        new_frame();
        px_run(16, 16'h0021, 15);
        px_run(6, 16'h0031, -1);
        idle(2);
        new_frame();
        chk("t4_ovf_sticky", ovf_err, 1);
        chk("t4_no_done", frame_done, 0);

        // Two full lines then frame end
        px_run(16, 16'h0041, -1);
        idle(2);
        px_run(16, 16'h0051, -1);
        idle(2);
        new_frame();
        chk("t5_frame_words", frame_words, 4);
        chk("t5_done_with_start", {frame_done, frame_start}, 2'b11);

        // Partial word discarded by vs edge, next word starts at lane 0
        px_run(5, 16'h0061, -1);
        new_frame();
        px_run(8, 16'h0071, -1);
        idle(2);

        // Pixel coincident with the vs edge lands in lane 0
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 16'h0AAA, 1'b1, 1'b0);
        px_run(N - 1, 16'h0081, -1);
        idle(3);
        chk("final_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
